// File: rtl/mips_enc_pkg.sv
// MIPS encoding constants, beat payload and word-assembly helpers for instr_encoder.
package mips_enc_pkg;

    localparam int unsigned WORD_W = 32;

    // ALU op codes as produced by the decode stage
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    // Primary opcodes
    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_SLTI = 6'h0A;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_JAL  = 6'h03;

    // R-form function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        JT_NONE = 3'd0,
        JT_J    = 3'd1,
        JT_JAL  = 3'd2
    } jump_t;

    // Word substituted for any bundle that cannot be encoded
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic              err;
    } enc_beat_t;

    function automatic logic [WORD_W-1:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                                 input logic [4:0] rd, input logic [5:0] fn);
        return {OPC_R, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [WORD_W-1:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                                 input logic [4:0] rt, input logic [15:0] imm16);
        return {opc, rs, rt, imm16};
    endfunction

    function automatic logic [WORD_W-1:0] j_word(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage

// File: rtl/instr_enc_comb.sv
// Combinational field-to-word encoder; unencodable bundles become NOP with err set.
// Jump forms are encoded only when INSTR_ENC_JUMP_EN is defined.
module instr_enc_comb
    import mips_enc_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [3:0]        op,
    input  logic              ssel,
    input  logic [DWIDTH-1:0] imm,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rdst_id,
    input  logic [2:0]        jump_type,
    input  logic [DWIDTH-7:0] jump_addr,
    output enc_beat_t         beat
);

    logic [DWIDTH-1:0] imm_sext;
    logic              imm_ok;
    logic [5:0]        fn;
    logic              fn_ok;

    // Immediate must survive truncation to 16 bits
    assign imm_sext = {{(DWIDTH-16){imm[15]}}, imm[15:0]};
    assign imm_ok   = (imm == imm_sext);

    // R-form function code lookup
    always_comb begin
        fn    = FN_ADD;
        fn_ok = 1'b1;
        case (op)
            OP_ADD:  fn = FN_ADD;
            OP_SUB:  fn = FN_SUB;
            OP_AND:  fn = FN_AND;
            OP_OR:   fn = FN_OR;
            OP_NOR:  fn = FN_NOR;
            OP_SLT:  fn = FN_SLT;
            default: fn_ok = 1'b0;
        endcase
    end

`ifndef INSTR_ENC_JUMP_EN
    logic unused_jump_addr;
    assign unused_jump_addr = ^jump_addr;
`endif

    // Form selection: jump overrides op/ssel, then register form, then immediate form
    always_comb begin
        beat.word = NOP_WORD;
        beat.err  = 1'b0;
        if (jump_type != 3'(JT_NONE)) begin
`ifdef INSTR_ENC_JUMP_EN
            if (jump_type == 3'(JT_J)) begin
                beat.word = j_word(OPC_J, jump_addr[25:0]);
            end else if (jump_type == 3'(JT_JAL)) begin
                beat.word = j_word(OPC_JAL, jump_addr[25:0]);
            end else begin
                beat.err = 1'b1;
            end
`else
            beat.err = 1'b1;
`endif
        end else if (ssel) begin
            if (fn_ok) begin
                beat.word = r_word(rs1_id, rs2_id, rdst_id, fn);
            end else begin
                beat.err = 1'b1;
            end
        end else if (imm_ok && (op == OP_ADD)) begin
            beat.word = i_word(OPC_ADDI, rs1_id, rdst_id, imm[15:0]);
        end else if (imm_ok && (op == OP_SLT)) begin
            beat.word = i_word(OPC_SLTI, rs1_id, rdst_id, imm[15:0]);
        end else begin
            beat.err = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder feeding an imem write port.
// Optional jump encoding: define INSTR_ENC_JUMP_EN.
module instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 256,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              ssel,
    input  logic [DWIDTH-1:0] imm,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rdst_id,
    input  logic [2:0]        jump_type,
    input  logic [DWIDTH-7:0] jump_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_instr,
    output logic [31:0]       out_addr,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    localparam logic [31:0] LAST_ADDR = BASE + 32'(4 * (DEPTH - 1));
    localparam logic [7:0]  ERR_MAX   = 8'hFF;

    enc_beat_t         enc_beat;
    logic              s1_valid;
    logic [DWIDTH-1:0] s1_word;
    logic              s1_err;
    logic              s2_free;
    logic              s1_free;
    logic              in_fire;
    logic              out_fire;

    instr_enc_comb #(
        .DWIDTH (DWIDTH)
    ) u_comb (
        .op        (op),
        .ssel      (ssel),
        .imm       (imm),
        .rs1_id    (rs1_id),
        .rs2_id    (rs2_id),
        .rdst_id   (rdst_id),
        .jump_type (jump_type),
        .jump_addr (jump_addr),
        .beat      (enc_beat)
    );

    // Handshake qualifiers; a stage is free if empty or its contents move on this edge
    assign s2_free  = !out_valid || out_ready;
    assign s1_free  = !s1_valid || s2_free;
    assign in_ready = !clr && s1_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Stage 1: capture encoded word on input handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_err   <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else begin
            if (s1_free) begin
                s1_valid <= in_fire;
            end
            if (in_fire) begin
                s1_word <= DWIDTH'(enc_beat.word);
                s1_err  <= enc_beat.err;
            end
        end
    end

    // Stage 2: output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= s1_word;
                out_err   <= s1_err;
            end
        end
    end

    // Byte address of the word at the output, wrapping after DEPTH words
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_addr <= BASE;
        end else if (clr) begin
            out_addr <= BASE;
        end else if (out_fire) begin
            out_addr <= (out_addr == LAST_ADDR) ? BASE : out_addr + 32'd4;
        end
    end

    // Saturating count of delivered error beats; survives clr
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (out_fire && out_err && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4 to exercise address wrap).
module tb_instr_encoder;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        ssel;
    logic [31:0] imm;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  rdst_id;
    logic [2:0]  jump_type;
    logic [25:0] jump_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_addr = 32'h0;

    instr_encoder #(
        .DWIDTH (32),
        .DEPTH  (4),
        .BASE   (32'h0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .ssel      (ssel),
        .imm       (imm),
        .rs1_id    (rs1_id),
        .rs2_id    (rs2_id),
        .rdst_id   (rdst_id),
        .jump_type (jump_type),
        .jump_addr (jump_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return (a == 32'hC) ? 32'h0 : a + 32'd4;
    endfunction

    task automatic set_fields(input logic [3:0] o, input logic s, input logic [31:0] im,
                              input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                              input logic [2:0] jt, input logic [25:0] ja);
        op = o; ssel = s; imm = im; rs1_id = a; rs2_id = b; rdst_id = d;
        jump_type = jt; jump_addr = ja;
    endtask

    // Present current fields until accepted; returns one step after the accepting edge
    task automatic send(output bit ok);
        bit fire;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire) ok = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    // Wait for and consume one output beat
    task automatic collect(output logic [31:0] w, output logic [31:0] a,
                           output logic e, output bit ok);
        ok = 1'b0;
        w = '0; a = '0; e = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                w = out_instr; a = out_addr; e = out_err; ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_addr = 32'h0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_instr !== 32'h0) $display("FAIL reset_instr: got %h expected 00000000", out_instr); else passed++;
        checks++; if (out_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 00000000", out_addr); else passed++;
        checks++; if (out_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", out_err); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); else passed++;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    endtask

    task automatic test_r_form();
        bit ok;
        set_fields(4'd2, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 26'h0);
        send(ok);
        checks++; if (ok !== 1'b1) $display("FAIL add_accept: got %b expected 1", ok); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL add_latency1: got %b expected 0", out_valid); else passed++;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) $display("FAIL add_latency2: got %b expected 1", out_valid); else passed++;
        checks++; if (out_instr !== 32'h00221820) $display("FAIL add_word: got %h expected 00221820", out_instr); else passed++;
        checks++; if (out_addr !== 32'h0) $display("FAIL add_addr: got %h expected 00000000", out_addr); else passed++;
        checks++; if (out_err !== 1'b0) $display("FAIL add_err: got %b expected 0", out_err); else passed++;
        @(posedge clk);
        #1;
        exp_addr = next_addr(exp_addr);
        checks++; if (out_valid !== 1'b0) $display("FAIL add_drained: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_i_form();
        bit ok;
        logic [31:0] w, a;
        logic e;
        pulse_clr();
        set_fields(4'd2, 1'b0, 32'hFFFF_FFFF, 5'd4, 5'd9, 5'd5, 3'd0, 26'h0);
        send(ok);
        set_fields(4'd7, 1'b0, 32'h0000_0007, 5'd0, 5'd0, 5'd2, 3'd0, 26'h0);
        send(ok);
        collect(w, a, e, ok);
        checks++; if (!ok || w !== 32'h2085FFFF || a !== 32'h0 || e !== 1'b0)
            $display("FAIL addi: got ok=%b w=%h a=%h e=%b expected w=2085ffff a=00000000 e=0", ok, w, a, e); else passed++;
        collect(w, a, e, ok);
        checks++; if (!ok || w !== 32'h28020007 || a !== 32'h4 || e !== 1'b0)
            $display("FAIL slti: got ok=%b w=%h a=%h e=%b expected w=28020007 a=00000004 e=0", ok, w, a, e); else passed++;
        exp_addr = 32'h8;
    endtask

    task automatic test_errors();
        bit ok;
        logic [31:0] w, a;
        logic e;
        set_fields(4'd2, 1'b0, 32'h0001_0000, 5'd1, 5'd0, 5'd2, 3'd0, 26'h0);
        send(ok);
        set_fields(4'hF, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 26'h0);
        send(ok);
        collect(w, a, e, ok);
        checks++; if (!ok || w !== 32'h0 || e !== 1'b1 || a !== exp_addr)
            $display("FAIL err_imm: got ok=%b w=%h a=%h e=%b expected w=00000000 a=%h e=1", ok, w, a, e, exp_addr); else passed++;
        exp_addr = next_addr(exp_addr);
        collect(w, a, e, ok);
        checks++; if (!ok || w !== 32'h0 || e !== 1'b1 || a !== exp_addr)
            $display("FAIL err_op: got ok=%b w=%h a=%h e=%b expected w=00000000 a=%h e=1", ok, w, a, e, exp_addr); else passed++;
        exp_addr = next_addr(exp_addr);
        checks++; if (err_cnt !== 8'd2) $display("FAIL err_cnt2: got %0d expected 2", err_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        logic [31:0] got_w [3];
        logic [31:0] got_a [3];
        int idx;
        int got;
        exp_w[0] = 32'h00221820;
        exp_w[1] = 32'h00A62022;
        exp_w[2] = 32'h01093825;
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            out_ready = (cyc >= 6);
            case (idx)
                0: set_fields(4'd2, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 26'h0);
                1: set_fields(4'd6, 1'b1, 32'h0, 5'd5, 5'd6, 5'd4, 3'd0, 26'h0);
                default: set_fields(4'd1, 1'b1, 32'h0, 5'd8, 5'd9, 5'd7, 3'd0, 26'h0);
            endcase
            in_valid = (idx < 3);
            @(negedge clk);
            if (cyc == 5) begin
                checks++; if (idx !== 2) $display("FAIL bp_accepted: got %0d expected 2", idx); else passed++;
                checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else passed++;
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                got_w[got] = out_instr;
                got_a[got] = out_addr;
                got++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (got !== 3) $display("FAIL bp_count: got %0d expected 3", got); else passed++;
        for (int k = 0; k < got; k++) begin
            checks++; if (got_w[k] !== exp_w[k] || got_a[k] !== exp_addr)
                $display("FAIL bp_beat%0d: got w=%h a=%h expected w=%h a=%h", k, got_w[k], got_a[k], exp_w[k], exp_addr); else passed++;
            exp_addr = next_addr(exp_addr);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got %b expected 0", out_valid); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap_clr();
        bit ok;
        logic [31:0] w, a;
        logic e;
        logic [31:0] exp_a [5];
        exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8; exp_a[3] = 32'hC; exp_a[4] = 32'h0;
        pulse_clr();
        checks++; if (err_cnt !== 8'd2) $display("FAIL clr_keeps_errcnt: got %0d expected 2", err_cnt); else passed++;
        for (int k = 0; k < 5; k++) begin
            set_fields(4'd2, 1'b1, 32'h0, 5'd1, 5'd2, 5'(k + 10), 3'd0, 26'h0);
            send(ok);
            collect(w, a, e, ok);
            checks++; if (!ok || a !== exp_a[k] || w !== (32'h00220020 | (32'(k + 10) << 11)))
                $display("FAIL wrap%0d: got ok=%b a=%h w=%h expected a=%h", k, ok, a, w, exp_a[k]); else passed++;
        end
        set_fields(4'd2, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 26'h0);
        send(ok);
        clr = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL clr_in_ready: got %b expected 0", in_ready); else passed++;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL clr_flush1: got %b expected 0", out_valid); else passed++;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL clr_flush2: got %b expected 0", out_valid); else passed++;
        set_fields(4'd0, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 26'h0);
        send(ok);
        collect(w, a, e, ok);
        checks++; if (!ok || a !== 32'h0 || w !== 32'h00221824)
            $display("FAIL clr_next: got ok=%b a=%h w=%h expected a=00000000 w=00221824", ok, a, w); else passed++;
        exp_addr = 32'h4;
    endtask

    task automatic test_jump();
        bit ok;
        logic [31:0] w, a;
        logic e;
        logic [31:0] exp_w;
        logic exp_e;
        logic [7:0] exp_cnt;
`ifdef INSTR_ENC_JUMP_EN
        exp_w = 32'h08000100; exp_e = 1'b0; exp_cnt = 8'd2;
`else
        exp_w = 32'h00000000; exp_e = 1'b1; exp_cnt = 8'd3;
`endif
        set_fields(4'd2, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 3'd1, 26'h100);
        send(ok);
        collect(w, a, e, ok);
        checks++; if (!ok || w !== exp_w || e !== exp_e || a !== exp_addr)
            $display("FAIL jump: got ok=%b w=%h e=%b a=%h expected w=%h e=%b a=%h", ok, w, e, a, exp_w, exp_e, exp_addr); else passed++;
        exp_addr = next_addr(exp_addr);
        checks++; if (err_cnt !== exp_cnt) $display("FAIL jump_errcnt: got %0d expected %0d", err_cnt, exp_cnt); else passed++;
    endtask

    task automatic test_err_sat();
        set_fields(4'hF, 1'b1, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 26'h0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (err_cnt !== 8'd255) $display("FAIL err_sat: got %0d expected 255", err_cnt); else passed++;
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [31:0] w, a;
        logic e;
        set_fields(4'd2, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 26'h0);
        send(ok);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd0 || out_addr !== 32'h0 || out_instr !== 32'h0)
            $display("FAIL async_reset: got v=%b cnt=%0d a=%h w=%h expected v=0 cnt=0 a=00000000 w=00000000",
                     out_valid, err_cnt, out_addr, out_instr); else passed++;
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL async_lost: got %b expected 0", out_valid); else passed++;
        set_fields(4'd7, 1'b1, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 26'h0);
        send(ok);
        collect(w, a, e, ok);
        checks++; if (!ok || a !== 32'h0 || w !== 32'h0022182A || e !== 1'b0)
            $display("FAIL async_after: got ok=%b a=%h w=%h e=%b expected a=00000000 w=0022182a e=0", ok, a, w, e); else passed++;
    endtask

    initial begin
        rstn = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_fields(4'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 26'h0);
        test_reset();
        test_r_form();
        test_i_form();
        test_errors();
        test_back_to_back();
        test_wrap_clr();
        test_jump();
        test_err_sat();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
